// File: rtl/uart_rx_fifo_if.sv
// Interface bundling the receiver side, consumer side and status
// signals of uart_rx_fifo. Slave is the FIFO; master is its environment.
interface uart_rx_fifo_if #(
  parameter int DATA_BIT_COUNT   = 8,
  parameter int DEPTH            = 16,
  parameter int DROP_COUNT_WIDTH = 8
);
  logic                        rx_ready;
  logic [DATA_BIT_COUNT-1:0]   rx_data;
  logic                        out_valid;
  logic [DATA_BIT_COUNT-1:0]   out_data;
  logic                        out_ack;
  logic [$clog2(DEPTH):0]      count;
  logic                        full;
  logic                        overflow;
  logic                        overflow_clear;
  logic [DROP_COUNT_WIDTH-1:0] drop_count;

  modport slave (
    input  rx_ready, rx_data, out_ack, overflow_clear,
    output out_valid, out_data, count, full, overflow, drop_count
  );

  modport master (
    output rx_ready, rx_data, out_ack, overflow_clear,
    input  out_valid, out_data, count, full, overflow, drop_count
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Byte FIFO behind a UART receiver: one push per rising edge of rx_ready,
// first-word-fall-through output, sticky overflow and saturating drop count.
module uart_rx_fifo #(
  parameter int DATA_BIT_COUNT   = 8,
  parameter int DEPTH            = 16,
  parameter int DROP_COUNT_WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  uart_rx_fifo_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DATA_BIT_COUNT-1:0]   mem_q [DEPTH];
  logic [PW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]               wr_ptr_q, wr_ptr_d;
  logic                        rx_ready_q;
  logic                        overflow_q, overflow_d;
  logic [DROP_COUNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  logic push_req, empty, full, pop, push_ok, drop;

  assign push_req = bus.rx_ready & ~rx_ready_q;
  assign empty    = (rd_ptr_q == wr_ptr_q);
  assign full     = (rd_ptr_q[AW-1:0] == wr_ptr_q[AW-1:0]) &&
                    (rd_ptr_q[AW] != wr_ptr_q[AW]);
  assign pop      = bus.out_ack & ~empty;
  // A full FIFO still accepts when the head is popped in the same cycle.
  assign push_ok  = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    // A drop coinciding with a clear wins: the flag stays set, count restarts at one.
    if (drop) begin
      overflow_d = 1'b1;
      if (bus.overflow_clear)
        drop_cnt_d = DROP_COUNT_WIDTH'(1);
      else if (!(&drop_cnt_q))
        drop_cnt_d = drop_cnt_q + 1'b1;
    end else if (bus.overflow_clear) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      rx_ready_q <= 1'b1;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      rx_ready_q <= bus.rx_ready;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= bus.rx_data;
  end

  assign bus.out_valid  = ~empty;
  assign bus.out_data   = mem_q[rd_ptr_q[AW-1:0]];
  assign bus.count      = wr_ptr_q - rd_ptr_q;
  assign bus.full       = full;
  assign bus.overflow   = overflow_q;
  assign bus.drop_count = drop_cnt_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo; accepted bytes go to a scoreboard queue
// that an independent monitor drains whenever the consumer pops.
module tb_uart_rx_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] exp_q [$];

  uart_rx_fifo_if #(.DATA_BIT_COUNT(8), .DEPTH(16), .DROP_COUNT_WIDTH(8)) bus ();

  uart_rx_fifo #(.DATA_BIT_COUNT(8), .DEPTH(16), .DROP_COUNT_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Monitor: the pop happens at the next rising edge, so the head is compared now.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ack) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected got %02h required no data", bus.out_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus.out_data !== e) begin
          errors++;
          $display("FAIL pop_data got %02h required %02h", bus.out_data, e);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h required %0h", name, act, req);
    end
  endtask

  // One received character: rx_ready low for a cycle, then high (left high).
  task automatic rx_byte(input logic [7:0] d, input bit accepted);
    bus.rx_ready = 1'b0;
    tick();
    bus.rx_data  = d;
    bus.rx_ready = 1'b1;
    if (accepted) exp_q.push_back(d);
    tick();
  endtask

  task automatic drain(input int n);
    bus.out_ack = 1'b1;
    tick(n);
    bus.out_ack = 1'b0;
  endtask

  initial begin
    bus.rx_ready       = 1'b1;
    bus.rx_data        = 8'h00;
    bus.out_ack        = 1'b0;
    bus.overflow_clear = 1'b0;
    tick(3);
    rst = 1'b0;

    // 1: ready already high through reset release
    chk("rst_full", bus.full, 0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_drop", bus.drop_count, 0);
    tick(20);
    chk("t1_count", bus.count, 0);
    chk("t1_valid", bus.out_valid, 0);

    // 2: three characters then three acks
    rx_byte(8'h41, 1);
    rx_byte(8'h42, 1);
    rx_byte(8'h43, 1);
    chk("t2_count", bus.count, 3);
    chk("t2_head", bus.out_data, 8'h41);
    drain(3);
    chk("t2_valid_after", bus.out_valid, 0);
    chk("t2_count_after", bus.count, 0);

    // 3: long high level yields one entry
    bus.rx_ready = 1'b0;
    tick();
    bus.rx_data  = 8'h55;
    bus.rx_ready = 1'b1;
    exp_q.push_back(8'h55);
    tick(50);
    chk("t3_count", bus.count, 1);
    drain(1);
    chk("t3_empty", bus.count, 0);

    // 4: fill, then two drops
    for (int i = 0; i < 16; i++) rx_byte(8'(i), 1);
    rx_byte(8'hAA, 0);
    rx_byte(8'hBB, 0);
    chk("t4_full", bus.full, 1);
    chk("t4_count", bus.count, 16);
    chk("t4_overflow", bus.overflow, 1);
    chk("t4_drop", bus.drop_count, 2);
    bus.overflow_clear = 1'b1;
    tick();
    bus.overflow_clear = 1'b0;
    chk("t4_clr_overflow", bus.overflow, 0);
    chk("t4_clr_drop", bus.drop_count, 0);

    // 5: push into full FIFO while popping
    bus.rx_ready = 1'b0;
    tick();
    bus.rx_data  = 8'hCC;
    bus.rx_ready = 1'b1;
    bus.out_ack  = 1'b1;
    exp_q.push_back(8'hCC);
    tick();
    bus.out_ack  = 1'b0;
    chk("t5_count", bus.count, 16);
    chk("t5_overflow", bus.overflow, 0);
    drain(16);
    chk("t5_drained", bus.count, 0);

    // 6: stream across pointer wrap with ack every other cycle
    for (int i = 0; i < 40; i++) begin
      bus.rx_ready = 1'b0;
      bus.out_ack  = 1'b1;
      tick();
      bus.out_ack  = 1'b0;
      bus.rx_data  = 8'(i);
      bus.rx_ready = 1'b1;
      exp_q.push_back(8'(i));
      tick();
    end
    drain(1);
    chk("t6_count", bus.count, 0);
    chk("t6_overflow", bus.overflow, 0);

    for (int i = 0; i < 16; i++) rx_byte(8'(8'h60 + i), 1);
    bus.rx_ready = 1'b0;
    tick();
    bus.rx_data        = 8'hEE;
    bus.rx_ready       = 1'b1;
    bus.overflow_clear = 1'b1;
    tick();
    bus.overflow_clear = 1'b0;
    chk("t6_set_wins_overflow", bus.overflow, 1);
    chk("t6_set_wins_drop", bus.drop_count, 1);
    bus.overflow_clear = 1'b1;
    tick();
    bus.overflow_clear = 1'b0;
    chk("t6_clear_overflow", bus.overflow, 0);
    chk("t6_clear_drop", bus.drop_count, 0);
    drain(16);
    chk("t6_drained", bus.count, 0);

    // Reset mid-operation discards buffered bytes
    rx_byte(8'h11, 0);
    rx_byte(8'h22, 0);
    chk("t7_pre_rst_count", bus.count, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("t7_rst_count", bus.count, 0);
    chk("t7_rst_valid", bus.out_valid, 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Byte buffer placed directly downstream of the UART receiver, between the receiver and the console mux arbitration logic. It detects each newly completed character from the receiver's level-type ready output and pushes the data word into a circular FIFO. It presents a first-word-fall-through valid/ack interface to the consumer. Overruns are flagged with a sticky flag and a saturating drop counter.

Parameters:
DATA_BIT_COUNT, 8, width of each received character (matches the receiver).
DEPTH, 16, FIFO entries; must be a power of two and at least 2.
DROP_COUNT_WIDTH, 8, width of the saturating dropped-byte counter.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
rst  input  1  asynchronous, active-high reset.
rx_ready  input  1  receiver ready level; goes high at the stop bit and stays high until the next start bit.
rx_data  input  DATA_BIT_COUNT  receiver data; valid while rx_ready is high.
out_valid  output  1  FIFO non-empty; out_data is valid.
out_data  output  DATA_BIT_COUNT  head-of-FIFO byte, first-word-fall-through.
out_ack  input  1  consumer pops the head at a clock edge where out_valid=1.
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
full  output  1  count==DEPTH.
overflow  output  1  sticky flag: at least one byte was dropped.
overflow_clear  input  1  clears overflow and drop_count.
drop_count  output  DROP_COUNT_WIDTH  number of dropped bytes, saturating at all-ones.

Behaviour:
- Reset (async assert, synchronous release):
  - rd_ptr=0, wr_ptr=0, count=0, out_valid=0, full=0, overflow=0, drop_count=0.
  - rx_ready_q=1. A receiver that is already showing ready when reset releases therefore does not produce a spurious push.
  - Memory contents are not reset.
  - A reset mid-operation discards all buffered bytes.
- Edge detect:
  - push_req = rx_ready & ~rx_ready_q, combinational.
  - rx_ready_q <= rx_ready every cycle.
  - Exactly one push per low-to-high transition of rx_ready. A level held high for any number of cycles produces one push.
  - rx_data is sampled at the same edge where push_req=1.
- Pointers:
  - rd_ptr and wr_ptr are each $clog2(DEPTH)+1 bits; the MSB is the wrap bit. The memory index is the lower bits.
  - Full when the indices are equal and the wrap bits differ. Empty when the pointers are equal.
  - count = wr_ptr - rd_ptr, modulo width.
- Pop:
  - pop = out_ack & out_valid.
  - out_ack is ignored when empty.
  - out_data = mem[rd_ptr index], combinational read. It is undefined (don't care) when out_valid=0.
- Push:
  - Accepted if not full, or if full and pop occur in the same cycle (slot freed; count unchanged).
  - On accept: mem[wr_ptr] <= rx_data, wr_ptr increments.
- Drop:
  - A push_req while full and no pop drops the byte.
  - overflow <= 1; drop_count increments unless already all-ones (no wrap).
- Simultaneous events:
  - Push and pop in the same cycle: both happen; count unchanged.
  - Push to an empty FIFO: out_valid=1 the cycle after the push edge (one-cycle latency from the rx_ready rise edge sample). The new byte is on out_data at that point.
  - overflow_clear and a drop in the same cycle: the set wins. overflow=1 and drop_count=1.
- Wrap-around: the pointers wrap naturally through 2*DEPTH values; no special handling is required.
- No other state machine beyond the edge detector. All outputs are registered or derived combinationally from registered pointers and flags.

Test Plan:
1. Reset with rx_ready=1, release, hold rx_ready high 20 cycles -> count stays 0, out_valid=0.
2. Three rx_ready pulses carrying 0x41, 0x42, 0x43, out_ack=0 -> count=3; out_data=0x41. Ack for 3 cycles -> out_data sequence 0x41, 0x42, 0x43, then out_valid=0, count=0.
3. Hold rx_ready high 50 cycles after one rise with rx_data=0x55 -> exactly one entry, count=1.
4. DEPTH=16: push 0x00..0x0F, then push 0xAA and 0xBB with no ack -> full=1, count=16, overflow=1, drop_count=2. Pops return 0x00..0x0F in order; 0xAA and 0xBB are never seen.
5. FIFO full, rx_ready rise with 0xCC in the same cycle as out_ack=1 -> count stays 16, overflow=0. 0xCC is the last byte popped.
6. Stream 40 bytes (0..39) with out_ack every other cycle, never overflowing -> output is 0..39 in order across pointer wrap.
   - Then a drop coincident with overflow_clear -> overflow=1, drop_count=1.
   - Then overflow_clear alone -> overflow=0, drop_count=0.
